hazard_ctrl_unit: RTL

Parametrised hazard controller for the 5-stage RV32 pipeline, replacing the forwarding-only hazard unit. It generates EX-stage operand forwarding selects and also provides load-use stalls, taken-branch flushes and multi-cycle execute (mul/div) stalls. It also keeps saturating stall and flush performance counters. It sits beside the pipeline top and drives the stall and flush enables of the F/D, D/E and E/M pipeline registers.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/hazard_ctrl_unit_md_stall_timer.sv | 28 ++
 rtl/hazard_ctrl_unit.sv | 99 +++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types, forwarding select codes and helpers for the hazard controller
package hazard_pkg;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_REG = 2'b00;
    localparam fwd_sel_t FWD_W   = 2'b01;
    localparam fwd_sel_t FWD_M   = 2'b10;

    // Counters of any width up to 64 bits share this; w gives the live width.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] max_v;
        max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= max_v) ? max_v : v + 64'd1;
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_md_stall_timer.sv
// rtl/hazard_ctrl_unit_md_stall_timer.sv - counts EX occupancy of a multi-cycle op and raises md_stall
module md_stall_timer #(
    parameter int MD_LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic md_op,
    output logic md_stall
);
    localparam int CW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MD_LAT - 1);

    logic [CW-1:0] md_cnt;
    logic          at_last;

    assign at_last  = (md_cnt == LAST);
    assign md_stall = !rst && md_op && !at_last;

    // Clearing when the op leaves or is squashed makes the next op start a full count.
    always_ff @(posedge clk) begin
        if (rst || !md_op || at_last) begin
            md_cnt <= '0;
        end else begin
            md_cnt <= md_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - forwarding, load-use/branch/multi-cycle hazard control and perf counters
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int MD_LAT = 4,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              load_e,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    input  logic              pc_src_e,
    input  logic              md_op_e,
    output logic [1:0]        forward_a_e,
    output logic [1:0]        forward_b_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_m,
    output logic              md_busy,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
);
    logic md_stall;
    logic lw_stall;

    md_stall_timer #(.MD_LAT(MD_LAT)) u_md_timer (
        .clk      (clk),
        .rst      (rst),
        .md_op    (md_op_e),
        .md_stall (md_stall)
    );

    function automatic fwd_sel_t fwd_for(input logic [REG_AW-1:0] rs);
        if (reg_write_m && rd_m != '0 && rd_m == rs) return FWD_M;
        if (reg_write_w && rd_w != '0 && rd_w == rs) return FWD_W;
        return FWD_REG;
    endfunction

    assign lw_stall = load_e && rd_e != '0 && (rd_e == rs1_d || rd_e == rs2_d);
    assign md_busy  = md_stall;

    always_comb begin
        forward_a_e = fwd_for(rs1_e);
        forward_b_e = fwd_for(rs2_e);
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_e     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        flush_m     = 1'b0;
        if (rst) begin
            forward_a_e = FWD_REG;
            forward_b_e = FWD_REG;
            flush_d     = 1'b1;
            flush_e     = 1'b1;
            flush_m     = 1'b1;
        end else if (md_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
        end else if (pc_src_e) begin
            // The DE instruction is squashed, so a pending load-use needs no stall.
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (lw_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_f) begin
                stall_cnt <= PERF_W'(sat_inc(64'(stall_cnt), PERF_W));
            end
            if (pc_src_e && !md_stall) begin
                flush_cnt <= PERF_W'(sat_inc(64'(flush_cnt), PERF_W));
            end
        end
    end

endmodule
